// File: rtl/piccolo_round_engine.sv
// Iterative Piccolo 64-bit block datapath: whitening, ROUNDS Feistel rounds with
// the byte round permutation, final whitening. Round keys are fetched by index.
module piccolo_round_engine #(
   parameter int ROUNDS      = 25,
   parameter int F_PER_CYCLE = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   input  logic [63:0] in_wk,
   output logic [4:0]  rk_idx,
   input  logic [31:0] rk_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data
);

   // Handshake: a block transfers on a rising edge where in_valid && in_ready;
   // a result transfers on a rising edge where out_valid && out_ready. in_ready
   // is high only in IDLE, and out_valid/out_data hold steady until taken.

   localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [63:0] x_q;
   logic [31:0] wk23_q;
   logic [4:0]  round_q;
   logic        phase_q;

   function automatic logic [3:0] sbox(input logic [3:0] n);
      logic [3:0] s;
      case (n)
         4'h0: s = 4'he;  4'h1: s = 4'h4;  4'h2: s = 4'hb;  4'h3: s = 4'h2;
         4'h4: s = 4'h3;  4'h5: s = 4'h8;  4'h6: s = 4'h0;  4'h7: s = 4'h9;
         4'h8: s = 4'h1;  4'h9: s = 4'ha;  4'ha: s = 4'h7;  4'hb: s = 4'hf;
         4'hc: s = 4'h6;  4'hd: s = 4'hc;  4'he: s = 4'h5;  default: s = 4'hd;
      endcase
      return s;
   endfunction

   // Multiply by x in GF(2^4) modulo x^4+x+1.
   function automatic logic [3:0] mul2(input logic [3:0] a);
      return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
   endfunction

   function automatic logic [15:0] f_func(input logic [15:0] x);
      logic [3:0] a0, a1, a2, a3, y0, y1, y2, y3;
      a0 = sbox(x[15:12]);
      a1 = sbox(x[11:8]);
      a2 = sbox(x[7:4]);
      a3 = sbox(x[3:0]);
      y0 = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
      y1 = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
      y2 = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
      y3 = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
      return {sbox(y0), sbox(y1), sbox(y2), sbox(y3)};
   endfunction

   logic [15:0] f_a;
   logic [15:0] f_b;

   generate
      if (F_PER_CYCLE == 2) begin : g_f_dual
         assign f_a = f_func(x_q[63:48]);
         assign f_b = f_func(x_q[31:16]);
      end else begin : g_f_shared
         // One F serves X0 in phase 0 and X2 in phase 1.
         logic [15:0] f_shared;
         assign f_shared = f_func(phase_q ? x_q[31:16] : x_q[63:48]);
         assign f_a      = f_shared;
         assign f_b      = f_shared;
      end
   endgenerate

   logic        upd_x1;
   logic        upd_x3;
   logic [63:0] mixed;
   logic [63:0] permuted;

   always_comb begin
      upd_x1   = (F_PER_CYCLE == 2) || !phase_q;
      upd_x3   = (F_PER_CYCLE == 2) || phase_q;
      mixed    = x_q;
      if (upd_x1) mixed[47:32] = x_q[47:32] ^ f_a ^ rk_data[31:16];
      if (upd_x3) mixed[15:0]  = x_q[15:0]  ^ f_b ^ rk_data[15:0];
      // Bytes b0..b7 (b0 = MSB) become b2,b7,b4,b1,b6,b3,b0,b5.
      permuted = {mixed[47:40], mixed[7:0],   mixed[31:24], mixed[55:48],
                  mixed[15:8],  mixed[39:32], mixed[63:56], mixed[23:16]};
   end

   assign rk_idx = round_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         x_q       <= '0;
         wk23_q    <= '0;
         round_q   <= '0;
         phase_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  x_q      <= in_data ^ {in_wk[63:48], 16'h0000, in_wk[47:32], 16'h0000};
                  wk23_q   <= in_wk[31:0];
                  round_q  <= '0;
                  phase_q  <= 1'b0;
                  in_ready <= 1'b0;
                  state_q  <= S_RUN;
               end
            end
            S_RUN: begin
               if (upd_x3) begin
                  phase_q <= 1'b0;
                  if (round_q == LAST_ROUND) begin
                     out_data  <= mixed ^ {wk23_q[31:16], 16'h0000, wk23_q[15:0], 16'h0000};
                     out_valid <= 1'b1;
                     round_q   <= '0;
                     state_q   <= S_DONE;
                  end else begin
                     x_q     <= permuted;
                     round_q <= round_q + 5'd1;
                  end
               end else begin
                  x_q     <= mixed;
                  phase_q <= 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_q   <= S_IDLE;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piccolo_round_engine.sv
// Bench for piccolo_round_engine: three instances (80-bit dual F, 80-bit shared F,
// 31 rounds) driven from a word-level Piccolo model with its own key schedules.
module tb_piccolo_round_engine;

   localparam logic [3:0] SBOX [16] = '{4'he, 4'h4, 4'hb, 4'h2, 4'h3, 4'h8, 4'h0, 4'h9,
                                        4'h1, 4'ha, 4'h7, 4'hf, 4'h6, 4'hc, 4'h5, 4'hd};
   localparam int MCOEF [16] = '{2, 3, 1, 1, 1, 2, 3, 1, 1, 1, 2, 3, 3, 1, 1, 2};
   localparam int RP [8] = '{2, 7, 4, 1, 6, 3, 0, 5};
   localparam logic [127:0] KEY80  = 128'h00112233445566778899;
   localparam logic [127:0] KEY128 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [63:0]  PT     = 64'h0123456789abcdef;
   localparam logic [63:0]  CT80   = 64'h8d2bff9935f84056;

   // ---------------- clock / reset / DUTs ----------------
   logic              clk = 1'b0;
   logic              rst_n;
   logic [2:0]        in_valid, in_ready, out_valid, out_ready;
   logic [2:0][63:0]  in_data, in_wk, out_data;
   logic [2:0][4:0]   rk_idx;
   logic [2:0][31:0]  rk_data;
   logic [31:0]       rk_tab [3][32];
   logic [63:0]       cur_wk [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_rk
      assign rk_data[g] = rk_tab[g][rk_idx[g]];
   end

   piccolo_round_engine #(.ROUNDS(25), .F_PER_CYCLE(2)) u_f2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .in_wk(in_wk[0]), .rk_idx(rk_idx[0]), .rk_data(rk_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]));

   piccolo_round_engine #(.ROUNDS(25), .F_PER_CYCLE(1)) u_f1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .in_wk(in_wk[1]), .rk_idx(rk_idx[1]), .rk_data(rk_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]));

   piccolo_round_engine #(.ROUNDS(31), .F_PER_CYCLE(2)) u_r31 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data[2]), .in_wk(in_wk[2]), .rk_idx(rk_idx[2]), .rk_data(rk_data[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]));

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int rounds_of(input int k);
      return (k == 2) ? 31 : 25;
   endfunction

   function automatic int gf_mul(input int a, input int b);
      int p;
      int aa;
      p  = 0;
      aa = a;
      for (int i = 0; i < 4; i++) begin
         if (((b >> i) & 1) != 0) p = p ^ aa;
         aa = aa << 1;
         if ((aa & 16) != 0) aa = aa ^ 19;
      end
      return p;
   endfunction

   function automatic logic [15:0] model_f(input logic [15:0] x);
      int          a [4];
      int          y [4];
      logic [15:0] r;
      for (int i = 0; i < 4; i++) a[i] = int'(SBOX[x[15-4*i -: 4]]);
      r = '0;
      for (int i = 0; i < 4; i++) begin
         y[i] = 0;
         for (int j = 0; j < 4; j++) y[i] = y[i] ^ gf_mul(MCOEF[4*i+j], a[j]);
         r[15-4*i -: 4] = SBOX[y[i]];
      end
      return r;
   endfunction

   function automatic logic [63:0] model_enc(input int k, input logic [63:0] pt,
                                             input logic [63:0] wk);
      logic [15:0] x [4];
      logic [7:0]  b [8];
      logic [31:0] rk;
      int          rounds;
      rounds = rounds_of(k);
      for (int j = 0; j < 4; j++) x[j] = pt[63-16*j -: 16];
      x[0] = x[0] ^ wk[63:48];
      x[2] = x[2] ^ wk[47:32];
      for (int r = 0; r < rounds; r++) begin
         rk   = rk_tab[k][r];
         x[1] = x[1] ^ model_f(x[0]) ^ rk[31:16];
         x[3] = x[3] ^ model_f(x[2]) ^ rk[15:0];
         if (r < rounds - 1) begin
            for (int i = 0; i < 8; i++) b[i] = x[i/2][15-8*(i%2) -: 8];
            for (int j = 0; j < 4; j++) x[j] = {b[RP[2*j]], b[RP[2*j+1]]};
         end
      end
      x[0] = x[0] ^ wk[31:16];
      x[2] = x[2] ^ wk[15:0];
      return {x[0], x[1], x[2], x[3]};
   endfunction

   // ---------------- key schedules ----------------
   logic [15:0] ks_rk [62];
   logic [63:0] ks_wk;

   function automatic logic [31:0] con_pair(input int i, input logic [31:0] mask);
      logic [31:0] c;
      c = 32'(i + 1);
      return ((c << 27) | (c << 17) | (c << 10) | c) ^ mask;
   endfunction

   task automatic ks80(input logic [79:0] key);
      logic [15:0] k [5];
      logic [15:0] a, b;
      logic [31:0] con;
      for (int j = 0; j < 5; j++) k[j] = key[79-16*j -: 16];
      ks_wk = {k[0][15:8], k[1][7:0], k[1][15:8], k[0][7:0],
               k[4][15:8], k[3][7:0], k[3][15:8], k[4][7:0]};
      for (int i = 0; i < 62; i++) ks_rk[i] = '0;
      for (int i = 0; i < 25; i++) begin
         con = con_pair(i, 32'h0f1e2d3c);
         case (i % 5)
            0, 2:    begin a = k[2]; b = k[3]; end
            1, 4:    begin a = k[0]; b = k[1]; end
            default: begin a = k[4]; b = k[4]; end
         endcase
         ks_rk[2*i]   = con[31:16] ^ a;
         ks_rk[2*i+1] = con[15:0] ^ b;
      end
   endtask

   task automatic ks128(input logic [127:0] key);
      logic [15:0] k [8];
      logic [15:0] t [8];
      logic [31:0] con;
      for (int j = 0; j < 8; j++) k[j] = key[127-16*j -: 16];
      ks_wk = {k[0][15:8], k[1][7:0], k[1][15:8], k[0][7:0],
               k[4][15:8], k[7][7:0], k[7][15:8], k[4][7:0]};
      for (int i = 0; i < 62; i++) begin
         if ((i + 2) % 8 == 0) begin
            t = k;
            k[0] = t[2]; k[1] = t[1]; k[2] = t[6]; k[3] = t[7];
            k[4] = t[0]; k[5] = t[3]; k[6] = t[4]; k[7] = t[5];
         end
         con = con_pair(i / 2, 32'h6547a98b);
         ks_rk[i] = k[(i+2)%8] ^ ((i % 2 == 0) ? con[31:16] : con[15:0]);
      end
   endtask

   // Decryption runs the same datapath: swap whitening halves and reverse the
   // round keys, exchanging the pair on every odd round.
   task automatic make_dec(input int rounds);
      logic [15:0] e [62];
      e     = ks_rk;
      ks_wk = {ks_wk[31:0], ks_wk[63:32]};
      for (int i = 0; i < rounds; i++) begin
         if (i % 2 == 0) begin
            ks_rk[2*i]   = e[2*rounds-2*i-2];
            ks_rk[2*i+1] = e[2*rounds-2*i-1];
         end else begin
            ks_rk[2*i]   = e[2*rounds-2*i-1];
            ks_rk[2*i+1] = e[2*rounds-2*i-2];
         end
      end
   endtask

   task automatic prep(input int k, input bit is128, input bit dec, input logic [127:0] key);
      if (is128) ks128(key);
      else ks80(key[79:0]);
      if (dec) make_dec(rounds_of(k));
      for (int i = 0; i < 32; i++) begin
         if (i < rounds_of(k)) rk_tab[k][i] = {ks_rk[2*i], ks_rk[2*i+1]};
         else rk_tab[k][i] = '0;
      end
      cur_wk[k] = ks_wk;
   endtask

   // ---------------- scoreboard ----------------
   logic [63:0] exp_q [$];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check64(input int k, input string name, input logic [63:0] act,
                          input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (dut%0d): got %h, expected %h", name, k, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic run_block(input int k, input logic [63:0] pt, input int stall, input bit noise);
      int          lat, exp_lat, w;
      bit          f1, seq_ok, hold_ok, rel_ok;
      logic [63:0] held, exp;
      f1      = (k == 1);
      exp_lat = f1 ? 2 * rounds_of(k) : rounds_of(k);
      exp     = exp_q.pop_front();
      @(negedge clk);
      in_data[k]  = pt;
      in_wk[k]    = cur_wk[k];
      in_valid[k] = 1'b1;
      w = 0;
      while (!in_ready[k] && w < 100) begin
         @(negedge clk);
         w++;
      end
      check64(k, "accept_ready", 64'(in_ready[k]), 64'd1);
      if (!in_ready[k]) begin
         in_valid[k] = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid[k] = 1'b0;
      lat    = -1;
      seq_ok = 1'b1;
      for (int c = 0; c < exp_lat + 20; c++) begin
         if (out_valid[k]) begin
            lat = c;
            break;
         end
         if (rk_idx[k] != 5'(f1 ? c / 2 : c) || in_ready[k]) seq_ok = 1'b0;
         if (noise) begin
            in_valid[k] = 1'($urandom_range(0, 1));
            in_data[k]  = {$urandom, $urandom};
            in_wk[k]    = {$urandom, $urandom};
         end
         @(negedge clk);
      end
      check64(k, "latency", 64'(lat), 64'(exp_lat));
      check64(k, "rk_sequence", 64'(seq_ok), 64'd1);
      if (lat < 0) begin
         in_valid[k] = 1'b0;
         return;
      end
      held    = out_data[k];
      hold_ok = 1'b1;
      for (int s = 0; s < stall; s++) begin
         if (!out_valid[k] || out_data[k] !== held || in_ready[k] || rk_idx[k] != 5'd0)
            hold_ok = 1'b0;
         if (noise) in_valid[k] = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      if (!out_valid[k] || out_data[k] !== held) hold_ok = 1'b0;
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      check64(k, "out_data", held, exp);
      check64(k, "stall_hold", 64'(hold_ok), 64'd1);
      @(posedge clk);
      @(negedge clk);
      out_ready[k] = 1'b0;
      rel_ok = !out_valid[k] && in_ready[k] && rk_idx[k] == 5'd0;
      check64(k, "release", 64'(rel_ok), 64'd1);
   endtask

   // ---------------- test ----------------
   typedef struct {
      int           k;
      bit           is128;
      bit           dec;
      logic [127:0] key;
      logic [63:0]  pt;
      logic [63:0]  exp;
   } vec_t;

   vec_t         vt [6];
   int           rk_k, w, st;
   bit           rdec, ok;
   logic [127:0] rkey;
   logic [63:0]  rpt;

   initial begin
      rst_n     = 1'b0;
      in_valid  = '0;
      out_ready = '0;
      in_data   = '0;
      in_wk     = '0;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 32; i++) rk_tab[k][i] = '0;
         cur_wk[k] = '0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check64(k, "reset_in_ready", 64'(in_ready[k]), 64'd1);
         check64(k, "reset_out_valid", 64'(out_valid[k]), 64'd0);
         check64(k, "reset_out_data", out_data[k], 64'd0);
         check64(k, "reset_rk_idx", 64'(rk_idx[k]), 64'd0);
      end
      rst_n = 1'b1;

      vt[0] = '{0, 1'b0, 1'b0, KEY80, PT, CT80};
      vt[1] = '{1, 1'b0, 1'b0, KEY80, PT, CT80};
      vt[2] = '{0, 1'b0, 1'b1, KEY80, CT80, PT};
      vt[3] = '{1, 1'b0, 1'b1, KEY80, CT80, PT};
      prep(2, 1'b1, 1'b0, KEY128);
      vt[4] = '{2, 1'b1, 1'b0, KEY128, PT, model_enc(2, PT, cur_wk[2])};
      vt[5] = '{2, 1'b1, 1'b1, KEY128, vt[4].exp, PT};

      for (int i = 0; i < 6; i++) begin
         prep(vt[i].k, vt[i].is128, vt[i].dec, vt[i].key);
         exp_q.push_back(vt[i].exp);
         run_block(vt[i].k, vt[i].pt, (i < 2) ? 7 : 1, 1'b1);
      end

      // Reset in the middle of round 10, then a clean block.
      prep(0, 1'b0, 1'b0, KEY80);
      @(negedge clk);
      in_data[0]  = PT;
      in_wk[0]    = cur_wk[0];
      in_valid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      w = 0;
      while (rk_idx[0] != 5'd10 && w < 60) begin
         @(negedge clk);
         w++;
      end
      check64(0, "reach_round10", 64'(rk_idx[0]), 64'd10);
      rst_n = 1'b0;
      #1;
      check64(0, "midreset_in_ready", 64'(in_ready[0]), 64'd1);
      check64(0, "midreset_out_valid", 64'(out_valid[0]), 64'd0);
      check64(0, "midreset_out_data", out_data[0], 64'd0);
      check64(0, "midreset_rk_idx", 64'(rk_idx[0]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (out_valid[0] || !in_ready[0]) ok = 1'b0;
      end
      check64(0, "no_partial_after_reset", 64'(ok), 64'd1);
      exp_q.push_back(CT80);
      run_block(0, PT, 2, 1'b0);

      // Randomised blocks, keys and stalls against the model.
      for (int n = 0; n < 1000; n++) begin
         rk_k = n % 3;
         rkey = {$urandom, $urandom, $urandom, $urandom};
         rpt  = {$urandom, $urandom};
         rdec = 1'($urandom_range(0, 1));
         st   = $urandom_range(0, 3);
         prep(rk_k, rk_k == 2, rdec, rkey);
         exp_q.push_back(model_enc(rk_k, rpt, cur_wk[rk_k]));
         run_block(rk_k, rpt, st, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
